// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS-32 fetch/decode slice:
//     - opcode localparams for the supported instruction subset
//     - LEGAL_OPS table used to build the legality match vector
//     - dec_t: the bundle of decoded fields held in the decode register
//     - is_zext_op(): opcodes whose 16-bit immediate is zero-extended
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int NUM_OPS = 14;

    // Every opcode this stage recognises; anything else decodes as illegal.
    localparam logic [NUM_OPS-1:0][5:0] LEGAL_OPS = {
        OP_RTYPE, OP_J,   OP_JAL,  OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
        OP_SLTI,  OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW,  OP_SW
    };

    // Decoded view of one latched instruction.
    typedef struct packed {
        logic [31:0] d_pc;
        logic [31:0] d_inst;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm_ext;
        logic [31:0] jtarget;
        logic        is_rtype;
        logic        is_jump;
        logic        is_itype;
        logic        illegal;
    } dec_t;

    // Logical-immediate ops treat the immediate as unsigned.
    function automatic logic is_zext_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/mips_field_decode.sv
// ---------------------------------------------------------------------------
// mips_field_decode
//   Purely combinational field decoder for one MIPS-32 instruction word.
//   Ports:
//     inst      in  32  instruction word
//     pc        in  32  address the word was fetched from
//     pc_plus   out 32  pc + PC_STEP (sequential successor, mod 2^32)
//     opcode/rs/rt/rd/shamt/funct  out  raw instruction fields
//     imm_ext   out 32  zero-extended for ANDI/ORI/XORI, sign-extended otherwise
//     jtarget   out 32  {pc_plus[31:28], inst[25:0], 2'b00}
//     is_rtype/is_jump/is_itype/illegal  out  instruction class flags
// ---------------------------------------------------------------------------
module mips_field_decode
    import mips_pkg::*;
#(
    parameter int PC_STEP = 4
) (
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic [31:0] pc_plus,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm_ext,
    output logic [31:0] jtarget,
    output logic        is_rtype,
    output logic        is_jump,
    output logic        is_itype,
    output logic        illegal
);

    logic [NUM_OPS-1:0] op_hit;

    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign shamt  = inst[10:6];
    assign funct  = inst[5:0];

    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 0.
    assign pc_plus = pc + 32'(PC_STEP);

    // Jump region comes from the successor of this instruction's own PC.
    assign jtarget = {pc_plus[31:28], inst[25:0], 2'b00};

    assign imm_ext = is_zext_op(opcode) ? {16'h0000, inst[15:0]}
                                        : {{16{inst[15]}}, inst[15:0]};

    // One comparator per supported opcode; legality is the OR of all hits.
    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_match
            assign op_hit[gi] = (opcode == LEGAL_OPS[gi]);
        end
    endgenerate

    assign illegal  = ~|op_hit;
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_jump  = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_itype = ~illegal && ~is_rtype && ~is_jump;

endmodule

// File: rtl/fetch_mod.sv
// ---------------------------------------------------------------------------
// fetch_mod
//   MIPS-32 fetch/decode register stage. Owns the fetch PC and a register
//   of decoded fields presented to the execute stage one cycle after the
//   instruction is accepted.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     inst, inst_valid    fetched word at address pc and its qualifier
//     stall               freeze PC and decode register
//     redir_valid/redir_pc  later-stage redirect; flushes d_valid
//     pc                  current fetch address
//     d_valid, d_pc, d_inst  latched instruction and its PC
//     opcode..funct, imm_ext, jtarget, is_rtype, is_jump, is_itype, illegal
//                         registered decoded fields
//   Edge priority: rst > redir_valid > stall > inst_valid.
// ---------------------------------------------------------------------------
module fetch_mod
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic [31:0] pc,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [31:0] d_inst,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm_ext,
    output logic [31:0] jtarget,
    output logic        is_rtype,
    output logic        is_jump,
    output logic        is_itype,
    output logic        illegal
);

    logic [31:0] pc_reg;
    logic        d_valid_reg;
    dec_t        dec_reg;
    dec_t        dec_next;
    logic [31:0] pc_plus;

    mips_field_decode #(
        .PC_STEP (PC_STEP)
    ) u_decode (
        .inst     (inst),
        .pc       (pc_reg),
        .pc_plus  (pc_plus),
        .opcode   (dec_next.opcode),
        .rs       (dec_next.rs),
        .rt       (dec_next.rt),
        .rd       (dec_next.rd),
        .shamt    (dec_next.shamt),
        .funct    (dec_next.funct),
        .imm_ext  (dec_next.imm_ext),
        .jtarget  (dec_next.jtarget),
        .is_rtype (dec_next.is_rtype),
        .is_jump  (dec_next.is_jump),
        .is_itype (dec_next.is_itype),
        .illegal  (dec_next.illegal)
    );

    assign dec_next.d_pc   = pc_reg;
    assign dec_next.d_inst = inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            d_valid_reg <= 1'b0;
            dec_reg     <= '0;
        end else if (redir_valid) begin
            // Flush: the decoded fields stay put but are no longer valid.
            pc_reg      <= redir_pc;
            d_valid_reg <= 1'b0;
        end else if (stall) begin
            // Hold everything.
        end else if (inst_valid) begin
            dec_reg     <= dec_next;
            d_valid_reg <= 1'b1;
            // Illegal opcodes are not jumps, so they advance sequentially.
            pc_reg      <= dec_next.is_jump ? dec_next.jtarget : pc_plus;
        end else begin
            d_valid_reg <= 1'b0;
        end
    end

    assign pc       = pc_reg;
    assign d_valid  = d_valid_reg;
    assign d_pc     = dec_reg.d_pc;
    assign d_inst   = dec_reg.d_inst;
    assign opcode   = dec_reg.opcode;
    assign rs       = dec_reg.rs;
    assign rt       = dec_reg.rt;
    assign rd       = dec_reg.rd;
    assign shamt    = dec_reg.shamt;
    assign funct    = dec_reg.funct;
    assign imm_ext  = dec_reg.imm_ext;
    assign jtarget  = dec_reg.jtarget;
    assign is_rtype = dec_reg.is_rtype;
    assign is_jump  = dec_reg.is_jump;
    assign is_itype = dec_reg.is_itype;
    assign illegal  = dec_reg.illegal;

endmodule

// File: tb/tb_fetch_mod.sv
// ---------------------------------------------------------------------------
// tb_fetch_mod
//   Directed and randomized stimulus for fetch_mod, checked every cycle
//   against a behavioural model of the stage (PC, valid flag, latched word
//   and its PC; decoded fields are computed arithmetically from those).
// ---------------------------------------------------------------------------
module tb_fetch_mod;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] pc;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_inst;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [31:0] jtarget;
    logic        is_rtype;
    logic        is_jump;
    logic        is_itype;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_dinst;
    logic [31:0] m_dpc;
    logic        m_dv;
    logic        m_has;

    always #5 clk = ~clk;

    fetch_mod #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .pc          (pc),
        .d_valid     (d_valid),
        .d_pc        (d_pc),
        .d_inst      (d_inst),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm_ext     (imm_ext),
        .jtarget     (jtarget),
        .is_rtype    (is_rtype),
        .is_jump     (is_jump),
        .is_itype    (is_itype),
        .illegal     (illegal)
    );

    // ---------------- model helpers (spec-level arithmetic) ----------------
    function automatic int m_op(input logic [31:0] w);
        return int'(w / 32'h0400_0000);
    endfunction

    function automatic logic m_legal(input int op);
        return op inside {0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 14, 15, 35, 43};
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] w);
        logic [31:0] lo;
        int op;
        lo = w % 32'h0001_0000;
        op = m_op(w);
        if (op == 12 || op == 13 || op == 14) return lo;
        if (lo >= 32'h0000_8000) return lo + 32'hFFFF_0000;
        return lo;
    endfunction

    function automatic logic [31:0] m_jt(input logic [31:0] w, input logic [31:0] ipc);
        logic [31:0] nxt;
        nxt = ipc + 32'd4;
        return (nxt & 32'hF000_0000) + (w % 32'h0400_0000) * 32'd4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] w;
        int op;
        w  = m_dinst;
        op = m_op(w);
        chk("pc", pc, m_pc);
        chk("d_valid", 32'(d_valid), 32'(m_dv));
        if (!m_has) begin
            chk("d_pc_rst", d_pc, 32'h0);
            chk("d_inst_rst", d_inst, 32'h0);
            chk("opcode_rst", 32'(opcode), 32'h0);
            chk("fields_rst", {rs, rt, rd, shamt, funct, 6'b0}, 32'h0);
            chk("imm_rst", imm_ext, 32'h0);
            chk("jt_rst", jtarget, 32'h0);
            chk("flags_rst", 32'({is_rtype, is_jump, is_itype, illegal}), 32'h0);
        end else begin
            chk("d_pc", d_pc, m_dpc);
            chk("d_inst", d_inst, w);
            chk("opcode", 32'(opcode), 32'(op));
            chk("rs", 32'(rs), (w / 32'h0020_0000) % 32);
            chk("rt", 32'(rt), (w / 32'h0001_0000) % 32);
            chk("rd", 32'(rd), (w / 32'h0000_0800) % 32);
            chk("shamt", 32'(shamt), (w / 32'h40) % 32);
            chk("funct", 32'(funct), w % 64);
            chk("imm_ext", imm_ext, m_imm(w));
            chk("jtarget", jtarget, m_jt(w, m_dpc));
            chk("is_rtype", 32'(is_rtype), 32'(op == 0));
            chk("is_jump", 32'(is_jump), 32'(op == 2 || op == 3));
            chk("is_itype", 32'(is_itype), 32'(m_legal(op) && op != 0 && op != 2 && op != 3));
            chk("illegal", 32'(illegal), 32'(!m_legal(op)));
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, check #1 later.
    task automatic step(input logic r, input logic iv, input logic [31:0] w,
                        input logic st, input logic rv, input logic [31:0] rp);
        int op;
        @(negedge clk);
        rst = r; inst_valid = iv; inst = w; stall = st;
        redir_valid = rv; redir_pc = rp;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_dv = 1'b0; m_has = 1'b0; m_dinst = 32'h0; m_dpc = 32'h0;
        end else if (rv) begin
            m_pc = rp; m_dv = 1'b0;
        end else if (st) begin
            m_dv = m_dv;
        end else if (iv) begin
            op = m_op(w);
            m_dinst = w; m_dpc = m_pc; m_has = 1'b1; m_dv = 1'b1;
            if (op == 2 || op == 3) m_pc = m_jt(w, m_pc);
            else m_pc = m_pc + 32'd4;
        end else begin
            m_dv = 1'b0;
        end
        #1;
        $display("step rst=%0b iv=%0b inst=%h stall=%0b redir=%0b/%h -> pc=%h d_valid=%0b",
                 r, iv, w, st, rv, rp, pc, d_valid);
        check_model();
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] rnd;
        logic [5:0]  op;
        int          pick;
        logic [5:0]  legal_tab [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                        6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        m_pc = 32'h0; m_dv = 1'b0; m_has = 1'b0; m_dinst = 32'h0; m_dpc = 32'h0;
        rst = 1'b1; inst_valid = 1'b0; inst = 32'h0; stall = 1'b0;
        redir_valid = 1'b0; redir_pc = 32'h0;

        // 1. reset for two cycles
        step(1, 0, 32'h0, 0, 0, 32'h0);
        step(1, 0, 32'h0, 0, 0, 32'h0);
        chk("t1_pc", pc, 32'h0);
        chk("t1_d_valid", 32'(d_valid), 32'h0);

        // 2. R-type at pc 0
        step(0, 1, 32'h02A3_3332, 0, 0, 32'h0);
        chk("t2_pc", pc, 32'h4);
        chk("t2_rs_rt_rd", {17'h0, rs, rt, rd}, {17'h0, 5'd21, 5'd3, 5'd6});
        chk("t2_shamt", 32'(shamt), 32'd12);
        chk("t2_funct", 32'(funct), 32'h32);
        chk("t2_is_rtype", 32'(is_rtype), 32'h1);

        // 3. J at pc 4
        step(0, 1, 32'h0AA3_3332, 0, 0, 32'h0);
        chk("t3_opcode", 32'(opcode), 32'h2);
        chk("t3_is_jump", 32'(is_jump), 32'h1);
        chk("t3_jtarget", jtarget, 32'h0A8C_CCC8);
        chk("t3_pc", pc, 32'h0A8C_CCC8);

        // 4. immediate extension
        step(0, 1, 32'h22A3_3332, 0, 0, 32'h0);
        chk("t4_is_itype", 32'(is_itype), 32'h1);
        chk("t4_imm_pos", imm_ext, 32'h0000_3332);
        step(0, 1, 32'h2063_8000, 0, 0, 32'h0);
        chk("t4_imm_sext", imm_ext, 32'hFFFF_8000);
        step(0, 1, 32'h3463_8000, 0, 0, 32'h0);
        chk("t4_imm_zext", imm_ext, 32'h0000_8000);

        // 5. stall holds; redirect beats stall
        held_pc = m_pc;
        step(0, 1, 32'h2000_1234, 1, 0, 32'h0);
        chk("t5_stall_pc", pc, held_pc);
        chk("t5_stall_imm", imm_ext, 32'h0000_8000);
        step(0, 1, 32'h2000_1234, 1, 1, 32'h0000_0100);
        chk("t5_redir_pc", pc, 32'h100);
        chk("t5_redir_valid", 32'(d_valid), 32'h0);

        // 6. illegal opcode and PC wrap
        step(0, 1, 32'hFC00_0000, 0, 0, 32'h0);
        chk("t6_illegal", 32'(illegal), 32'h1);
        chk("t6_d_valid", 32'(d_valid), 32'h1);
        chk("t6_pc", pc, 32'h104);
        step(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        step(0, 1, 32'h22A3_3332, 0, 0, 32'h0);
        chk("t6_wrap_pc", pc, 32'h0);
        step(0, 0, 32'h0, 0, 0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rnd  = $urandom;
            pick = int'($urandom_range(0, 19));
            if (pick < 17) op = legal_tab[$urandom_range(0, 13)];
            else op = 6'($urandom);
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 {op, rnd[25:0]},
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0),
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
